// File: rtl/sid_pkg.sv
// Shared SID register-map constants, bus-latch timing defaults and write-queue payload.
package sid_pkg;

  localparam int unsigned NUM_VOICES   = 3;
  localparam int unsigned VOICE_STRIDE = 7;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned TTL_W        = 24;
  localparam int unsigned FIFO_DEPTH   = 2;

  localparam logic [ADDR_W-1:0] ADDR_FC_LO    = 5'h15;
  localparam logic [ADDR_W-1:0] ADDR_FC_HI    = 5'h16;
  localparam logic [ADDR_W-1:0] ADDR_RES_FILT = 5'h17;
  localparam logic [ADDR_W-1:0] ADDR_MODE_VOL = 5'h18;
  localparam logic [ADDR_W-1:0] ADDR_POT_X    = 5'h19;
  localparam logic [ADDR_W-1:0] ADDR_POT_Y    = 5'h1A;
  localparam logic [ADDR_W-1:0] ADDR_OSC3     = 5'h1B;
  localparam logic [ADDR_W-1:0] ADDR_ENV3     = 5'h1C;

  localparam logic [TTL_W-1:0] BUS_TTL_6581_DEF = 24'h001D00;
  localparam logic [TTL_W-1:0] BUS_TTL_8580_DEF = 24'h0A2000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sid_wr_fifo.sv
// Two-entry CPU write queue; a push into a full queue replaces the newest entry.
module sid_wr_fifo
  import sid_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t wdata,
  output wr_entry_t rdata,
  output logic      empty,
  output logic      ovf_c
);

  logic [1:0] count;
  wr_entry_t  mem [FIFO_DEPTH];
  logic       pop_ok;

  assign pop_ok = pop & (count != 2'd0);
  assign empty  = (count == 2'd0);
  assign rdata  = mem[0];
  assign ovf_c  = push & ~pop_ok & (count == 2'(FIFO_DEPTH));

  // mem[0] is always the oldest entry; popping shifts mem[1] down.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      case ({push, pop_ok})
        2'b11: begin
          if (count == 2'd1) begin
            mem[0] <= wdata;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= wdata;
          end
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            mem[0] <= wdata;
            count  <= 2'd1;
          end else begin
            mem[1] <= wdata;
            count  <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sid_reg_ctrl.sv
// SID register file: queued CPU writes committed on the 1 MHz tick, read mux and
// decaying data-bus latch.
module sid_reg_ctrl
  import sid_pkg::*;
#(
  parameter logic [TTL_W-1:0] BUS_TTL_6581 = BUS_TTL_6581_DEF,
  parameter logic [TTL_W-1:0] BUS_TTL_8580 = BUS_TTL_8580_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ce_1m,
  input  logic                        mode,
  input  logic                        cs,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  input  logic [DATA_W-1:0]           pot_x,
  input  logic [DATA_W-1:0]           pot_y,
  input  logic [DATA_W-1:0]           osc3,
  input  logic [DATA_W-1:0]           env3,
  output logic [NUM_VOICES-1:0][15:0] freq,
  output logic [NUM_VOICES-1:0][11:0] pw,
  output logic [NUM_VOICES-1:0][7:0]  control,
  output logic [NUM_VOICES-1:0][7:0]  att_dec,
  output logic [NUM_VOICES-1:0][7:0]  sus_rel,
  output logic [10:0]                 fc,
  output logic [7:0]                  res_filt,
  output logic [7:0]                  mode_vol,
  output logic                        wr_ovf
);

  logic              wr_c;
  logic              rd_c;
  logic              commit_c;
  logic              empty;
  logic              ovf_c;
  wr_entry_t         head;
  wr_entry_t         wentry;
  logic [DATA_W-1:0] bus_latch;
  logic [TTL_W-1:0]  decay_cnt;

  assign wr_c     = cs & we;
  assign rd_c     = cs & ~we;
  assign commit_c = ce_1m & ~empty;
  assign wentry   = '{addr: addr, data: data_in};

  sid_wr_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_c),
    .pop   (ce_1m),
    .wdata (wentry),
    .rdata (head),
    .empty (empty),
    .ovf_c (ovf_c)
  );

  // Register file updated only from the queue head on a tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq     <= '0;
      pw       <= '0;
      control  <= '0;
      att_dec  <= '0;
      sus_rel  <= '0;
      fc       <= '0;
      res_filt <= '0;
      mode_vol <= '0;
    end else if (commit_c) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (head.addr == 5'(v * VOICE_STRIDE + 0)) freq[v][7:0]   <= head.data;
        if (head.addr == 5'(v * VOICE_STRIDE + 1)) freq[v][15:8]  <= head.data;
        if (head.addr == 5'(v * VOICE_STRIDE + 2)) pw[v][7:0]     <= head.data;
        if (head.addr == 5'(v * VOICE_STRIDE + 3)) pw[v][11:8]    <= head.data[3:0];
        if (head.addr == 5'(v * VOICE_STRIDE + 4)) control[v]     <= head.data;
        if (head.addr == 5'(v * VOICE_STRIDE + 5)) att_dec[v]     <= head.data;
        if (head.addr == 5'(v * VOICE_STRIDE + 6)) sus_rel[v]     <= head.data;
      end
      if (head.addr == ADDR_FC_LO)    fc[2:0]  <= head.data[2:0];
      if (head.addr == ADDR_FC_HI)    fc[10:3] <= head.data;
      if (head.addr == ADDR_RES_FILT) res_filt <= head.data;
      if (head.addr == ADDR_MODE_VOL) mode_vol <= head.data;
    end
  end

  // Bus latch: reloaded at capture time, fades to zero after the mode's TTL.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_latch <= '0;
      decay_cnt <= '0;
    end else if (wr_c) begin
      bus_latch <= data_in;
      decay_cnt <= mode ? BUS_TTL_8580 : BUS_TTL_6581;
    end else if (ce_1m && decay_cnt != '0) begin
      decay_cnt <= decay_cnt - TTL_W'(1);
      if (decay_cnt == TTL_W'(1)) bus_latch <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
      wr_ovf   <= 1'b0;
    end else begin
      if (ovf_c) wr_ovf <= 1'b1;
      if (rd_c) begin
        case (addr)
          ADDR_POT_X: data_out <= pot_x;
          ADDR_POT_Y: data_out <= pot_y;
          ADDR_OSC3:  data_out <= osc3;
          ADDR_ENV3:  data_out <= env3;
          default:    data_out <= bus_latch;
        endcase
      end
    end
  end

endmodule

// File: doc/sid_reg_ctrl.md
SID_REG_CTRL -- requirements
Module: sid_reg_ctrl

Interface
REQ-001 SHALL have parameter BUS_TTL_6581, default 24'h001D00, data-bus latch decay time for the 6581, in ce_1m ticks.
REQ-002 SHALL have parameter BUS_TTL_8580, default 24'h0A2000, data-bus latch decay time for the 8580, in ce_1m ticks.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
  clock  in  1  system clock.
  reset  in  1  reset, synchronous, active-high.
  ce_1m  in  1  1 MHz SID tick, one clock wide.
  mode  in  1  0 = 6581, 1 = 8580.
  cs  in  1  chip select.
  we  in  1  write strobe, qualified by cs.
  addr  in  5  register address 0x00-0x1F.
  data_in  in  8  CPU write data.
  data_out  out  8  registered read data.
  pot_x  in  8  paddle X value.
  pot_y  in  8  paddle Y value.
  osc3  in  8  voice 3 osc_out.
  env3  in  8  voice 3 env_out.
  freq  out  3x16  per-voice frequency.
  pw  out  3x12  per-voice pulse width.
  control  out  3x8  per-voice control byte.
  att_dec  out  3x8  per-voice attack/decay.
  sus_rel  out  3x8  per-voice sustain/release.
  fc  out  11  filter cutoff.
  res_filt  out  8  resonance/routing.
  mode_vol  out  8  filter mode/volume.
  wr_ovf  out  1  sticky write-queue overflow flag.

Function
REQ-004 SHALL capture each clock with cs&we into a 2-entry write FIFO of {addr, data_in}.
REQ-005 SHALL pop and commit at most one FIFO entry per ce_1m, so all voice outputs change only on ce_1m clocks.
REQ-006 SHALL, when a push and a pop coincide, perform both; an entry pushed on a ce_1m clock into an empty FIFO SHALL commit on the next ce_1m, not the same one.
REQ-007 SHALL, on push into a full FIFO without a coinciding pop, overwrite the newest entry and set wr_ovf; wr_ovf clears only on reset.
REQ-008 SHALL decode committed writes per voice base v*7: +0 freq[7:0], +1 freq[15:8], +2 pw[7:0], +3 pw[11:8] from data[3:0], +4 control, +5 att_dec, +6 sus_rel.
REQ-009 SHALL decode 0x15 fc[2:0] from data[2:0], 0x16 fc[10:3], 0x17 res_filt, 0x18 mode_vol; committed writes to 0x19-0x1F SHALL change no register.
REQ-010 SHALL load the bus latch with data_in and reload the decay counter with the mode-selected TTL on every captured write, at capture time, independent of the FIFO.
REQ-011 SHALL decrement the decay counter on each ce_1m while it is non-zero, and clear the bus latch on the ce_1m that makes it reach zero.
REQ-012 SHALL register data_out one clock after cs&~we: 0x19 pot_x, 0x1A pot_y, 0x1B osc3, 0x1C env3, any other address the bus latch; data_out holds its value otherwise.
REQ-013 SHALL let a read of 0x19-0x1C leave the bus latch and decay counter unchanged.
REQ-014 SHALL apply a mode change only to the next counter reload, never to a countdown already in progress.

Reset
REQ-015 SHALL, on reset, clear all register outputs, data_out, wr_ovf, the bus latch, the decay counter and the FIFO; reset SHALL take priority over a coinciding write or ce_1m.
REQ-016 SHALL discard any queued write when reset is asserted while the FIFO is non-empty.

Structure
REQ-017 SHALL place the register address constants (voice stride 7, 0x15-0x1C) and both TTL defaults in the shared sid_pkg package.
REQ-018 SHALL implement the write queue as a sub-module named sid_wr_fifo, 2 entries x 13 bits.

Verification
REQ-019 Write 0x04=0x41 and 0x00=0x34 on consecutive clocks between ticks -> control[0]=0x41 after the 1st ce_1m, freq[0][7:0]=0x34 after the 2nd, wr_ovf=0.
REQ-020 Three writes 0x0E=0x11, 0x0E=0x22, 0x0E=0x33 on consecutive clocks before any ce_1m -> freq[2][7:0] ends at 0x33, with 0x22 lost, and wr_ovf=1.
REQ-021 mode=0, write 0x18=0x5A, then read 0x00 each tick -> 0x5A until 0x1D00 ticks elapse, 0x00 afterwards; mode=1 -> 0x5A held for 0xA2000 ticks.
REQ-022 osc3=0xC3, env3=0x7E, pot_x=0x10 -> reads of 0x1B/0x1C/0x19 return 0xC3/0x7E/0x10 one clock after select, with the bus latch unchanged.
REQ-023 Write 0x03=0xFF, then 0x16=0xAB and 0x15=0x07 -> pw[0][11:8]=0xF, fc=11'h55F.
REQ-024 Write queued, reset asserted before ce_1m -> all outputs remain 0 after the next ce_1m.
